// File: rtl/ldl_count_v2_if.sv
// rtl/ldl_count_v2_if.sv - control/window/status bundle for the ldl_count_v2 counter
interface ldl_count_v2_if #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
) ();
    logic              clr;
    logic              load;
    logic [WIDTH-1:0]  load_val;
    logic              en;
    logic              dir;
    logic [STEP_W-1:0] step;
    logic [WIDTH-1:0]  min;
    logic [WIDTH-1:0]  max;
    logic [WIDTH-1:0]  dout;
    logic              tc;
    logic              ovf;

    modport master (
        output clr, load, load_val, en, dir, step, min, max,
        input  dout, tc, ovf
    );

    modport slave (
        input  clr, load, load_val, en, dir, step, min, max,
        output dout, tc, ovf
    );
endinterface

// File: rtl/ldl_count_v2.sv
// rtl/ldl_count_v2.sv - windowed up/down counter with step, wrap/saturate, tc pulse and sticky ovf
module ldl_count_v2 #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4,
    parameter int MODE   = 0,
    parameter int SAT    = 0
) (
    input  logic           clk,
    input  logic           rst,
    ldl_count_v2_if.slave  bus
);
    localparam int CW = ((WIDTH > STEP_W) ? WIDTH : STEP_W) + 1;

    logic [WIDTH-1:0] dout_q, dout_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;

    logic             down;
    logic             illegal;
    logic             term;
    logic [WIDTH-1:0] start_val;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] step_next;
    logic [CW-1:0]    step_ext, cur_ext, min_ext, max_ext;

    always_comb begin
        down      = (MODE == 1) ? 1'b1 : ((MODE == 2) ? bus.dir : 1'b0);
        start_val = down ? bus.max : bus.min;
        illegal   = (bus.min > bus.max);

        step_ext = (bus.step == '0) ? CW'(1) : CW'(bus.step);
        cur_ext  = CW'(dout_q);
        min_ext  = CW'(bus.min);
        max_ext  = CW'(bus.max);

        // Out-of-window values on the far side of the terminal count as terminal.
        term = illegal || (down ? (dout_q <= bus.min) : (dout_q >= bus.max));

        // Only evaluated when not terminal, so the differences below cannot go negative.
        if (down) begin
            step_next = (step_ext > cur_ext - min_ext) ? bus.min : WIDTH'(cur_ext - step_ext);
        end else begin
            step_next = (step_ext > max_ext - cur_ext) ? bus.max : WIDTH'(cur_ext + step_ext);
        end

        if (illegal || bus.load_val < bus.min) begin
            load_clamped = bus.min;
        end else if (bus.load_val > bus.max) begin
            load_clamped = bus.max;
        end else begin
            load_clamped = bus.load_val;
        end

        dout_d = dout_q;
        tc_d   = 1'b0;
        ovf_d  = ovf_q;
        if (rst || bus.clr) begin
            dout_d = start_val;
            ovf_d  = 1'b0;
        end else if (bus.load) begin
            dout_d = load_clamped;
        end else if (bus.en) begin
            if (term) begin
                tc_d  = 1'b1;
                ovf_d = 1'b1;
                if (SAT == 0) begin
                    dout_d = start_val;
                end
            end else begin
                dout_d = step_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        dout_q <= dout_d;
        tc_q   <= tc_d;
        ovf_q  <= ovf_d;
    end

    assign bus.dout = dout_q;
    assign bus.tc   = tc_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_ldl_count_v2.sv
// tb/tb_ldl_count_v2.sv - four counter configurations driven in parallel and checked against an integer model
module tb_ldl_count_v2;
    // k0: up/wrap, k1: down/saturate, k2: runtime/wrap, k3: runtime/saturate
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_val = 8'd0;
    logic       en = 1'b0;
    logic       dir = 1'b0;
    logic [3:0] step = 4'd1;
    logic [7:0] min_v = 8'd0;
    logic [7:0] max_v = 8'd255;

    logic [7:0] o_dout [4];
    logic       o_tc   [4];
    logic       o_ovf  [4];

    int  m_dout [4];
    bit  m_tc   [4];
    bit  m_ovf  [4];
    bit  m_valid = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : gd
        ldl_count_v2_if #(.WIDTH(8), .STEP_W(4)) bus ();
        assign bus.clr      = clr;
        assign bus.load     = load;
        assign bus.load_val = load_val;
        assign bus.en       = en;
        assign bus.dir      = dir;
        assign bus.step     = step;
        assign bus.min      = min_v;
        assign bus.max      = max_v;
        ldl_count_v2 #(
            .WIDTH(8), .STEP_W(4),
            .MODE((g == 0) ? 0 : ((g == 1) ? 1 : 2)),
            .SAT((g == 1 || g == 3) ? 1 : 0)
        ) u_dut (
            .clk(clk),
            .rst(rst),
            .bus(bus)
        );
        assign o_dout[g] = bus.dout;
        assign o_tc[g]   = bus.tc;
        assign o_ovf[g]  = bus.ovf;
    end

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            automatic bit dn    = (k == 1) || (k >= 2 && dir);
            automatic bit sat   = (k == 1 || k == 3);
            automatic int lo    = int'(min_v);
            automatic int hi    = int'(max_v);
            automatic int cur   = m_dout[k];
            automatic int st    = (step == 0) ? 1 : int'(step);
            automatic int start = dn ? hi : lo;
            automatic int nd    = cur;
            automatic bit ntc   = 1'b0;
            automatic bit novf  = m_ovf[k];
            if (rst || clr) begin
                nd = start;
                novf = 1'b0;
            end else if (load) begin
                if (lo > hi || int'(load_val) < lo) nd = lo;
                else if (int'(load_val) > hi) nd = hi;
                else nd = int'(load_val);
            end else if (en) begin
                if (lo > hi || (dn ? cur <= lo : cur >= hi)) begin
                    ntc = 1'b1;
                    novf = 1'b1;
                    if (!sat) nd = start;
                end else if (dn) begin
                    nd = (cur - st < lo) ? lo : cur - st;
                end else begin
                    nd = (cur + st > hi) ? hi : cur + st;
                end
            end
            m_dout[k] <= nd;
            m_tc[k]   <= ntc;
            m_ovf[k]  <= novf;
        end
        if (rst) m_valid <= 1'b1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            for (int k = 0; k < 4; k++) begin
                n_tests += 3;
                if (int'(o_dout[k]) != m_dout[k]) begin
                    n_fail++;
                    $display("FAIL model dout[%0d] @%0t: got %0d expected %0d", k, $time, o_dout[k], m_dout[k]);
                end
                if (o_tc[k] !== m_tc[k]) begin
                    n_fail++;
                    $display("FAIL model tc[%0d] @%0t: got %0b expected %0b", k, $time, o_tc[k], m_tc[k]);
                end
                if (o_ovf[k] !== m_ovf[k]) begin
                    n_fail++;
                    $display("FAIL model ovf[%0d] @%0t: got %0b expected %0b", k, $time, o_ovf[k], m_ovf[k]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input int act, input int exp_v);
        n_tests++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    initial begin
        int ed [6];
        int et [6];

        // Up, step 3, wrap at 10
        min_v = 8'd0; max_v = 8'd10; step = 4'd3; en = 1'b1; dir = 1'b0; rst = 1'b1;
        tick();
        chk("reset dout k0", int'(o_dout[0]), 0);
        chk("reset tc k0", int'(o_tc[0]), 0);
        chk("reset ovf k0", int'(o_ovf[0]), 0);
        rst = 1'b0;
        ed = '{3, 6, 9, 10, 0, 3};
        et = '{0, 0, 0, 0, 1, 0};
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("upwrap dout %0d", i), int'(o_dout[0]), ed[i]);
            chk($sformatf("upwrap tc %0d", i), int'(o_tc[0]), et[i]);
        end
        chk("upwrap ovf", int'(o_ovf[0]), 1);

        // Down, step 4, saturate at 5
        min_v = 8'd5; max_v = 8'd20; step = 4'd4; rst = 1'b1;
        tick();
        chk("down reset dout k1", int'(o_dout[1]), 20);
        rst = 1'b0;
        ed = '{16, 12, 8, 5, 5, 5};
        et = '{0, 0, 0, 0, 1, 1};
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("downsat dout %0d", i), int'(o_dout[1]), ed[i]);
            chk($sformatf("downsat tc %0d", i), int'(o_tc[1]), et[i]);
        end
        chk("downsat ovf", int'(o_ovf[1]), 1);

        // Runtime direction, step 0 behaves as 1
        min_v = 8'd0; max_v = 8'd255; step = 4'd0; dir = 1'b0; rst = 1'b1;
        tick();
        chk("rt reset dout k2", int'(o_dout[2]), 0);
        rst = 1'b0;
        repeat (3) tick();
        chk("rt up3 dout", int'(o_dout[2]), 3);
        dir = 1'b1;
        ed[0:3] = '{2, 1, 0, 255};
        et[0:3] = '{0, 0, 0, 1};
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("rt down dout %0d", i), int'(o_dout[2]), ed[i]);
            chk($sformatf("rt down tc %0d", i), int'(o_tc[2]), et[i]);
        end
        dir = 1'b0;
        tick();
        chk("rt up wrap dout", int'(o_dout[2]), 0);
        chk("rt up wrap tc", int'(o_tc[2]), 1);

        // Priority: load over en, clr over load/en, load clamp
        min_v = 8'd0; max_v = 8'd10; step = 4'd3; rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (6) tick();
        chk("prio pre dout", int'(o_dout[0]), 3);
        chk("prio pre ovf", int'(o_ovf[0]), 1);
        load = 1'b1; load_val = 8'd7;
        tick();
        chk("prio load dout", int'(o_dout[0]), 7);
        clr = 1'b1;
        tick();
        chk("prio clr dout", int'(o_dout[0]), 0);
        chk("prio clr ovf", int'(o_ovf[0]), 0);
        clr = 1'b0; load_val = 8'd200; max_v = 8'd50;
        tick();
        chk("prio clamp dout", int'(o_dout[0]), 50);
        load = 1'b0;

        // Window change under a running count, then illegal window
        max_v = 8'd100; step = 4'd10; en = 1'b0; clr = 1'b1;
        tick();
        clr = 1'b0; en = 1'b1;
        repeat (4) tick();
        chk("win pre dout", int'(o_dout[0]), 40);
        max_v = 8'd30;
        tick();
        chk("win shrink dout", int'(o_dout[0]), 0);
        chk("win shrink tc", int'(o_tc[0]), 1);
        min_v = 8'd50; max_v = 8'd40;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk($sformatf("illegal dout %0d", i), int'(o_dout[0]), 50);
            chk($sformatf("illegal tc %0d", i), int'(o_tc[0]), 1);
        end

        // Reset while saturated at terminal
        min_v = 8'd0; max_v = 8'd5; step = 4'd2; dir = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (4) tick();
        chk("rstmid pre dout", int'(o_dout[3]), 5);
        chk("rstmid pre tc", int'(o_tc[3]), 1);
        chk("rstmid pre ovf", int'(o_ovf[3]), 1);
        rst = 1'b1;
        tick();
        chk("rstmid dout", int'(o_dout[3]), 0);
        chk("rstmid tc", int'(o_tc[3]), 0);
        chk("rstmid ovf", int'(o_ovf[3]), 0);
        rst = 1'b0;
        tick();
        chk("rstmid resume", int'(o_dout[3]), 2);

        // Randomized traffic, checked every cycle by the model
        for (int i = 0; i < 600; i++) begin
            rst  = ($urandom_range(0, 99) < 2);
            clr  = ($urandom_range(0, 99) < 4);
            load = ($urandom_range(0, 99) < 6);
            en   = ($urandom_range(0, 99) < 75);
            dir  = 1'($urandom_range(0, 1));
            step = 4'($urandom_range(0, 15));
            load_val = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 99) < 8) begin
                min_v = 8'($urandom_range(0, 100));
                max_v = 8'($urandom_range(0, 200));
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ldl_count_v2.md
# ldl_count_v2

Parametrised successor to the basic wrap counter. Counts within a runtime-programmable window [min, max], with a programmable step, a fixed or runtime-selected direction, and wrap or saturate behaviour at the terminal value. Supports synchronous clear and parallel load, and flags terminal events with a registered `tc` pulse and a sticky `ovf` flag. Used as the generic timer / address / credit counter in the datapath and control blocks.

## Interface
- `WIDTH`, 8: counter width; `min`, `max`, `load_val` and `dout` share this width.
- `STEP_W`, 4: width of the `step` input.
- `MODE`, 0: direction. 0 = increment, 1 = decrement, 2 = runtime, taken from `dir`.
- `SAT`, 0: terminal behaviour. 0 = wrap, 1 = saturate (hold at the terminal value).
- `clk`, in, 1: clock, rising edge.
- `rst`, in, 1: reset, synchronous, active-high.
- `clr`, in, 1: synchronous clear to the start value.
- `load`, in, 1: parallel load of `load_val`.
- `load_val`, in, WIDTH: load value.
- `en`, in, 1: count enable, one step per enabled cycle.
- `dir`, in, 1: 0 = up, 1 = down. Only used when MODE=2.
- `step`, in, STEP_W: step size. A value of 0 is treated as 1.
- `min`, in, WIDTH: lower bound, inclusive.
- `max`, in, WIDTH: upper bound, inclusive.
- `dout`, out, WIDTH: count value, registered.
- `tc`, out, 1: registered terminal pulse.
- `ovf`, out, 1: sticky terminal flag, registered.

## Operation
- **Effective direction `d`**: MODE 0 gives up; MODE 1 gives down; MODE 2 gives `dir`.
- **Start value**: `min` if `d` is up, `max` if `d` is down. Evaluated in the current cycle.
- **Terminal value**: `max` if up, `min` if down.
- **Update priority per cycle**: rst > clr > load > en > hold.
- **rst**: `dout` goes to the start value, `tc`=0, `ovf`=0. In MODE 2 the start value uses `dir` sampled in the reset cycle.
- **clr**: `dout` goes to the start value, `tc`=0, `ovf`=0.
- **load**: `dout` ← `load_val` clamped to [min, max]. Below `min` loads `min`; above `max` loads `max`. `tc`=0. `ovf` is unchanged.
- **en, up**:
  - Terminal condition is `dout >= max`.
  - Not terminal: `dout` ← `dout + step`, clamped to `max`. Clamp when `step > max - dout`. No intermediate overflow is allowed; compute in WIDTH+1 bits.
- **en, down**:
  - Terminal condition is `dout <= min`.
  - Not terminal: `dout` ← `dout - step`, clamped to `min`. Clamp when `step > dout - min`.
- **en at terminal, SAT=0**: `dout` ← start value for `d` (wrap), `tc`=1, `ovf`=1.
- **en at terminal, SAT=1**: `dout` holds, `tc`=1, `ovf`=1. `tc` repeats on every enabled cycle at the terminal value.
- **Clamping never sets `tc`**. Landing exactly on the terminal value takes one step; the following enabled step is the terminal event.
- **`dout` outside the window after a runtime change to `min`/`max`**:
  - Up with `dout > max`: terminal.
  - Up with `dout < min`: steps normally.
  - Down mirrors this (down with `dout < min` is terminal; down with `dout > max` steps normally).
- **`min > max` (illegal window)**:
  - Every enabled step is a terminal event.
  - SAT=0 wraps to the start value; SAT=1 holds.
  - load yields `min` (the lower clamp is applied first).
  - Behaviour is deterministic; no assertion is raised in RTL.
- **Direction change in MODE 2** takes effect on the same-cycle step. No extra state.
- **`tc` is 0** on any cycle without an enabled terminal step, including hold cycles.

## Timing
- Single-cycle latency: inputs sampled at edge N are visible on `dout`/`tc`/`ovf` after edge N.
- `tc` is high for exactly the one cycle following an enabled terminal step. In the wrap case it coincides with `dout` showing the start value.
- `ovf` sets with `tc` and stays set until `rst` or `clr`.
- `rst`/`clr` asserted mid-count override `en` and `load` in the same cycle; counting resumes from the start value on the next enabled cycle.
- There are no combinational paths from inputs to outputs.

## Test plan
- **Up, step and wrap**: WIDTH=8, MODE=0, SAT=0, min=0, max=10, step=3, en held high from reset.
  - `dout` = 0,3,6,9,10,0,3.
  - `tc` = 1 only with the second 0.
  - `ovf` = 1 from then on.
- **Down, saturate**: MODE=1, SAT=1, min=5, max=20, step=4.
  - `dout` = 20,16,12,8,5,5,5.
  - `tc` high on each cycle after the first 5 is shown (two pulses).
  - `ovf`=1.
- **Runtime direction**: MODE=2, min=0, max=255, step=0 (treated as 1).
  - Start at reset with `dir`=0: `dout`=0.
  - Three up steps give 3; `dir`=1 and four steps give 2,1,0,255 with `tc` once; `dir`=0 and one step give 0 with `tc`.
- **Priority**:
  - `load`=1, `load_val`=7 together with `en`=1 at `dout`=3: `dout`=7.
  - Next cycle `clr`+`load`+`en`: `dout`=min, `ovf`=0.
  - `load_val`=200 with max=50: `dout`=50.
- **Window change**: counting up at `dout`=40, change max to 30 with `en`=1.
  - Next `dout`=min and `tc`=1.
  - Then set min=50, max=40 (illegal): every enabled cycle gives `tc`=1, with `dout`=50 under SAT=0.
- **Reset mid-operation**: SAT=1 at the terminal value with `ovf`=1, assert `rst` with `en`=1.
  - `dout`=start value, `tc`=0, `ovf`=0.
  - Counting resumes on the first cycle after `rst` deasserts.
